// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared types and constants for the MEM pipeline stage. Holds the
//            access FSM state encoding, the RISC-V load/store funct3 size
//            codes and the default data-memory timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Access FSM: wait for an access, wait for the memory, release the pipe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3 size/sign codes. Any other code is handled as a full word.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Cycles spent in BUSY without an ack before the access is abandoned.
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 64;

  function automatic logic is_byte_op(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half_op(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Purely combinational byte-lane steering for the MEM stage.
//            Load side : picks the byte/half/word out of the raw memory word
//                        and sign- or zero-extends it.
//            Store side: produces byte enables and replicates the store data
//                        into every lane so the memory can pick any of them.
// Ports    : ld_funct3_i [3]  load size/sign code
//            ld_lane_i   [2]  load byte offset (addr[1:0])
//            rdata_i     [32] raw word from memory
//            ld_data_o   [32] aligned, extended load data
//            st_funct3_i [3]  store size code
//            st_lane_i   [2]  store byte offset (addr[1:0])
//            wdata_i     [32] store data (rs2)
//            st_be_o     [4]  store byte enables
//            st_wdata_o  [32] lane-replicated store data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lane_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load lane selection and extension.
  always_comb begin
    byte_sel  = rdata_i[7:0];
    half_sel  = rdata_i[15:0];
    ld_data_o = rdata_i;

    case (ld_lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    // Halfwords only look at addr[1]; addr[0] is the misalignment bit.
    half_sel = ld_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data_o = {24'h0, byte_sel};
      F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data_o = {16'h0, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

  // Store byte enables and data replication.
  always_comb begin
    st_be_o    = 4'hF;
    st_wdata_o = wdata_i;

    case (st_funct3_i)
      F3_B: begin
        st_be_o    = 4'b0001 << st_lane_i;
        st_wdata_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        st_be_o    = 4'b0011 << {st_lane_i[1], 1'b0};
        st_wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'hF;
        st_wdata_o = wdata_i;
      end
    endcase
  end

endmodule : dmem_lane_align
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of the 5-stage pipeline. Issues loads and stores to a
//            variable-latency data memory over a req/ack handshake, stalls
//            the upstream pipe until the access finishes, and hands aligned,
//            extended load data to the MEM/WB register.
// Config   : MEM_ALIGN_CHECK_EN - when defined, misaligned half/word accesses
//            are refused (no request) and flagged on misalign_o.
// Params   : TIMEOUT_CYC - BUSY cycles without ack before abort (1..255)
// Ports    : clk_i, rst_i (async, active-high)
//            mem_read_i, mem_write_i, funct3_i[3], addr_i[32], wdata_i[32]
//            stall_o, dm_o[32], err_o
//            dmem_req_o, dmem_we_o, dmem_addr_o[32], dmem_wdata_o[32],
//            dmem_be_o[4], dmem_ack_i, dmem_rdata_i[32]
//            misalign_o (MEM_ALIGN_CHECK_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] dm_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] dm_q, dm_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        access;
  logic        misaligned;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // A simultaneous read+write is a store; mem_write_i alone decides we.
  assign access = mem_read_i | mem_write_i;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misaligned = 1'b0;
    if (is_byte_op(funct3_i)) begin
      misaligned = 1'b0;
    end else if (is_half_op(funct3_i)) begin
      misaligned = addr_i[0];
    end else begin
      misaligned = (addr_i[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  // Load side works on the captured size/lane so it does not depend on the
  // upstream register staying frozen; store side works on the live inputs
  // because the request is built in IDLE.
  dmem_lane_align u_lane_align (
    .ld_funct3_i (f3_q),
    .ld_lane_i   (lane_q),
    .rdata_i     (dmem_rdata_i),
    .ld_data_o   (ld_data),
    .st_funct3_i (funct3_i),
    .st_lane_i   (addr_i[1:0]),
    .wdata_i     (wdata_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      dm_q    <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      dm_q    <= dm_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    dm_d    = dm_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          // Stall must be visible in this very cycle so EX/MEM holds.
          stall_o = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = mem_write_i ? st_be : 4'hF;
          f3_d    = funct3_i;
          lane_d  = addr_i[1:0];
          cnt_d   = 8'h0;
          state_d = BUSY;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (access) begin
          misalign_d = 1'b1;
        end
`endif
      end

      BUSY: begin
        stall_o = 1'b1;
        if (dmem_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 8'h0;
          state_d = DONE;
          if (!we_q) begin
            dm_d = ld_data;
          end
        end else if (cnt_q == TIMEOUT_LIM - 8'd1) begin
          // This is the TIMEOUT_CYC-th BUSY cycle with no ack: give up.
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          dm_d    = 32'h0;
          cnt_d   = 8'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // Pipeline advances on this edge; the inputs still show the old
        // instruction, so they must not start another access.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dm_o         = dm_q;
  assign err_o        = err_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Expected load results
//            are queued when an access is driven and compared when the stage
//            releases the stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        stall_o;
  logic [31:0] dm_o;
  logic        err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  typedef struct {
    string       tag;
    logic [31:0] dm;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_dm = 32'h0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .dm_o         (dm_o),
    .err_o        (err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference load extraction, written as shift-then-truncate.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    case (f3)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b100:  return {24'h0, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // One access: drive, let the memory answer after ack_dly BUSY cycles
  // (negative = never), then compare against the queued expectation.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int ack_dly, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_dm,
                            input logic exp_err, input int exp_stalls);
    exp_t e;
    int   stalls;
    int   busy_n;
    int   guard;
    e.tag = tag; e.dm = exp_dm; e.err = exp_err; e.stalls = exp_stalls;
    @(posedge clk_i); #1;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
    exp_q.push_back(e);
    stalls = 0; busy_n = 0; guard = 0;
    forever begin
      @(negedge clk_i);
      if (!stall_o) break;
      stalls++;
      if (dmem_req_o) begin
        if (busy_n == 0) begin
          check_eq({tag, ".we"}, {31'h0, dmem_we_o}, {31'h0, wr});
          check_eq({tag, ".addr"}, dmem_addr_o, {addr[31:2], 2'b00});
          check_eq({tag, ".be"}, {28'h0, dmem_be_o}, {28'h0, exp_be});
          if (wr) check_eq({tag, ".wdata"}, dmem_wdata_o, exp_wdata);
        end
        if (busy_n == ack_dly) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        end
        busy_n++;
      end
      @(posedge clk_i); #1;
      dmem_ack_i = 1'b0;
      guard++;
      if (guard > 400) begin
        check_eq({tag, ".stall_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    // In DONE: stall released, result visible.
    e = exp_q.pop_front();
    check_eq({e.tag, ".dm"}, dm_o, e.dm);
    check_eq({e.tag, ".err"}, {31'h0, err_o}, {31'h0, e.err});
    check_eq({e.tag, ".stalls"}, stalls, e.stalls);
    check_eq({e.tag, ".req_done"}, {31'h0, dmem_req_o}, 32'h0);
    // Leave DONE with inputs still present: must return to IDLE, not re-issue.
    @(posedge clk_i); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(negedge clk_i);
    check_eq({e.tag, ".no_retrig"}, {31'h0, dmem_req_o}, 32'h0);
    check_eq({e.tag, ".err_pulse"}, {31'h0, err_o}, 32'h0);
    check_eq({e.tag, ".dm_hold"}, dm_o, e.dm);
  endtask

  initial begin
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [31:0] a, r, exp_v;
    int          d;

    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

    // Reset state
    #12;
    check_eq("rst.req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("rst.we", {31'h0, dmem_we_o}, 32'h0);
    check_eq("rst.addr", dmem_addr_o, 32'h0);
    check_eq("rst.wdata", dmem_wdata_o, 32'h0);
    check_eq("rst.be", {28'h0, dmem_be_o}, 32'h0);
    check_eq("rst.dm", dm_o, 32'h0);
    check_eq("rst.err", {31'h0, err_o}, 32'h0);
    check_eq("rst.stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b0;

    // lw, ack in first BUSY cycle
    run_access("lw100", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               4'hF, 32'h0, 32'hDEADBEEF, 0, 2);
    // lb / lbu upper lane
    run_access("lb103", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
               4'hF, 32'h0, 32'hFFFFFF80, 0, 3);
    run_access("lbu103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0,
               4'hF, 32'h0, 32'h00000080, 0, 2);
    // lh / lhu
    run_access("lh102", 1, 0, 3'b001, 32'h102, 32'h0, 32'h9234_5678, 2,
               4'hF, 32'h0, 32'hFFFF9234, 0, 4);
    run_access("lhu100", 1, 0, 3'b101, 32'h100, 32'h0, 32'h1234_A678, 0,
               4'hF, 32'h0, 32'h0000A678, 0, 2);
    // Undefined funct3 loads as a word
    run_access("lx011", 1, 0, 3'b011, 32'h10C, 32'h0, 32'hCAFE_F00D, 0,
               4'hF, 32'h0, 32'hCAFEF00D, 0, 2);
    model_dm = 32'hCAFEF00D;
    // Stores leave dm_o untouched
    run_access("sh202", 0, 1, 3'b001, 32'h202, 32'h0000_1234, 32'hFFFF_FFFF, 0,
               4'b1100, 32'h12341234, model_dm, 0, 2);
    run_access("sb101", 0, 1, 3'b000, 32'h101, 32'h0000_00AB, 32'h0, 1,
               4'b0010, 32'hABABABAB, model_dm, 0, 3);
    run_access("sw", 0, 1, 3'b010, 32'h204, 32'h0BAD_CAFE, 32'h0, 0,
               4'hF, 32'h0BADCAFE, model_dm, 0, 2);
    // Read and write together behave as a store
    run_access("rw", 1, 1, 3'b000, 32'h003, 32'h0000_0055, 32'h1111_1111, 0,
               4'b1000, 32'h55555555, model_dm, 0, 2);

    // Randomised aligned loads with variable latency
    for (int i = 0; i < 8; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      a  = {$urandom_range(0, 32'h3FFF), 2'b00} + 32'h1000;
      if (f3 == 3'b000 || f3 == 3'b100) a[1:0] = 2'($urandom_range(0, 3));
      else if (f3 == 3'b001 || f3 == 3'b101) a[1] = 1'($urandom_range(0, 1));
      r = $urandom;
      d = $urandom_range(0, 4);
      exp_v = model_load(f3, a[1:0], r);
      run_access($sformatf("rnd%0d", i), 1, 0, f3, a, 32'h0, r, d,
                 4'hF, 32'h0, exp_v, 0, 2 + d);
    end

    // Timeout: never acked
    run_access("tmo", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, -1,
               4'hF, 32'h0, 32'h0, 1, TO + 1);

    // Load something non-zero, then reset mid-BUSY
    run_access("pre_rst", 1, 0, 3'b010, 32'h400, 32'h0, 32'h7777_7777, 0,
               4'hF, 32'h0, 32'h77777777, 0, 2);
    @(posedge clk_i); #1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
    @(posedge clk_i); #1;
    check_eq("mid.req_busy", {31'h0, dmem_req_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    check_eq("mid.req_rst", {31'h0, dmem_req_o}, 32'h0);
    mem_read_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
    @(posedge clk_i); #1;
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    check_eq("mid.dm", dm_o, 32'h0);
    check_eq("mid.req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("mid.stall", {31'h0, stall_o}, 32'h0);
    check_eq("mid.err", {31'h0, err_o}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk_i); #1;
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h101;
    @(negedge clk_i);
    check_eq("mis.stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i); #1;
    mem_read_i = 1'b0;
    check_eq("mis.pulse", {31'h0, misalign_o}, 32'h1);
    check_eq("mis.req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("mis.dm", dm_o, 32'h0);
    @(posedge clk_i); #1;
    check_eq("mis.pulse_end", {31'h0, misalign_o}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_access_stage
`default_nettype wire
